// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one read or write per request, parameterised strobe timing.
// Every SRAM-facing pin comes straight from a flop so the bus never glitches.
module sram_ctrl #(
  parameter int unsigned D_WIDTH  = 8,
  parameter int unsigned A_WIDTH  = 15,
  parameter int unsigned RD_WAIT  = 4,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned WR_HOLD  = 4
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_addr,
  input  logic [D_WIDTH-1:0] i_wdata,
  output logic               o_ready,
  output logic               o_ack,
  output logic [D_WIDTH-1:0] o_rdata,
  output logic [A_WIDTH-1:0] o_ram_a,
  inout  wire  [D_WIDTH-1:0] io_ram_d,
  output logic               o_ram_n_oe,
  output logic               o_ram_n_we,
  output logic               o_ram_n_cs
);

  localparam int unsigned MAX_AB = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int unsigned MAX_CD = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
  localparam int unsigned MAX_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  // Counter holds "cycles remaining minus one" for the current timed state.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WR_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWs, StWp, StWh, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [D_WIDTH-1:0] r_rdata;
  logic               r_n_cs, r_n_oe, r_n_we, r_drive;
  logic               w_accept, w_capture, w_last;
  logic               w_n_cs, w_n_oe, w_n_we, w_drive;

  assign w_last = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_req) begin
          w_accept  = 1'b1;
          w_state_d = i_we ? StWs : StRd;
          w_cnt_d   = i_we ? WS_LOAD : RD_LOAD;
        end
      end
      StRd: begin
        if (w_last) begin
          w_capture = 1'b1;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StWs: begin
        if (w_last) begin
          w_state_d = StWp;
          w_cnt_d   = WP_LOAD;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StWp: begin
        if (w_last) begin
          w_state_d = StWh;
          w_cnt_d   = WH_LOAD;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StWh: begin
        if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Pin values are decoded from the next state and registered alongside it.
    w_n_cs  = !(w_state_d inside {StRd, StWs, StWp, StWh});
    w_n_oe  = (w_state_d != StRd);
    w_n_we  = (w_state_d != StWp);
    w_drive = (w_state_d inside {StWs, StWp, StWh});
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_n_cs  <= 1'b1;
      r_n_oe  <= 1'b1;
      r_n_we  <= 1'b1;
      r_drive <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_capture) begin
        r_rdata <= io_ram_d;
      end
      r_n_cs  <= w_n_cs;
      r_n_oe  <= w_n_oe;
      r_n_we  <= w_n_we;
      r_drive <= w_drive;
    end
  end

  assign io_ram_d   = r_drive ? r_wdata : {D_WIDTH{1'bz}};
  assign o_ram_a    = r_addr;
  assign o_ram_n_cs = r_n_cs;
  assign o_ram_n_oe = r_n_oe;
  assign o_ram_n_we = r_n_we;
  assign o_rdata    = r_rdata;
  assign o_ready    = (r_state == StIdle);
  assign o_ack      = (r_state == StDone);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: async SRAM model with 55 ns output delay, bus monitor and a
// reference memory; each task drives one scenario and checks it against expected timing.
module tb_sram_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 15;
  localparam int RDW    = 4;
  localparam int WS     = 1;
  localparam int WP     = 2;
  localparam int WH     = 4;
  localparam int RD_LAT = RDW + 1;
  localparam int WR_LAT = WS + WP + WH + 1;
  localparam logic [DW-1:0] FLOAT = {DW{1'b1}};  // pulled-up idle bus value

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, ack, ram_n_oe, ram_n_we, ram_n_cs;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_a;
  tri1  [DW-1:0] ram_d;

  int checks = 0;
  int errors = 0;

  sram_ctrl #(
    .D_WIDTH (DW),
    .A_WIDTH (AW),
    .RD_WAIT (RDW),
    .WR_SETUP(WS),
    .WR_PULSE(WP),
    .WR_HOLD (WH)
  ) u_dut (
    .i_clk     (clk),
    .i_n_rst   (n_rst),
    .i_req     (req),
    .i_we      (we),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_ready   (ready),
    .o_ack     (ack),
    .o_rdata   (rdata),
    .o_ram_a   (ram_a),
    .io_ram_d  (ram_d),
    .o_ram_n_oe(ram_n_oe),
    .o_ram_n_we(ram_n_we),
    .o_ram_n_cs(ram_n_cs)
  );

  always #10 clk = ~clk;

  // Async SRAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_dout = '0;
  logic          sram_drv = 1'b0;
  assign ram_d = sram_drv ? sram_dout : {DW{1'bz}};

  always @(negedge ram_n_oe) begin
    #55;
    if (!ram_n_oe && !ram_n_cs) begin
      sram_dout = mem[ram_a];
      sram_drv  = 1'b1;
    end
  end
  always @(posedge ram_n_oe) sram_drv = 1'b0;
  always @(posedge ram_n_we) if (n_rst === 1'b1 && ram_n_cs === 1'b0) mem[ram_a] = ram_d;

  // Reference model: what each written address should hold, and the expected rdata
  logic [DW-1:0] ref_mem [int];
  int            addr_q[$];
  logic [DW-1:0] last_rd = '0;

  // Bus monitor
  bit   mon_en = 1'b0;
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ram_n_oe === 1'b0 && ram_n_we === 1'b0) begin
        errors++;
        $display("FAIL mon_oe_we n_oe=%b n_we=%b at %0t", ram_n_oe, ram_n_we, $time);
      end
      checks++;
      if (ram_n_oe === 1'b0 && !sram_drv && ram_d !== FLOAT) begin
        errors++;
        $display("FAIL mon_drive_on_read bus=%h exp %h at %0t", ram_d, FLOAT, $time);
      end
      checks++;
      if (ram_n_cs === 1'b1 && ram_d !== FLOAT) begin
        errors++;
        $display("FAIL mon_idle_bus bus=%h exp %h at %0t", ram_d, FLOAT, $time);
      end
      checks++;
      if (ack === 1'b1 && prev_ack === 1'b1) begin
        errors++;
        $display("FAIL mon_ack_width ack high two cycles at %0t", $time);
      end
      prev_ack = ack;
    end
  end

  // Issue one access from a negedge; returns cycles to ack (-1 on timeout) and rdata at ack.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    rd = rdata;
    if (w) begin
      ref_mem[int'(a)] = d;
      addr_q.push_back(int'(a));
    end
  endtask

  task automatic test_reset();
    #1 n_rst = 1'b0;
    #4;
    checks++;
    if ({ready, ack} !== 2'b10) begin
      errors++; $display("FAIL reset_ready_ack got %b exp 10", {ready, ack});
    end
    checks++;
    if (rdata !== '0 || ram_a !== '0) begin
      errors++; $display("FAIL reset_regs rdata=%h ram_a=%h exp 0", rdata, ram_a);
    end
    checks++;
    if ({ram_n_cs, ram_n_oe, ram_n_we} !== 3'b111 || ram_d !== FLOAT) begin
      errors++;
      $display("FAIL reset_pins ctl=%b bus=%h exp 111/%h", {ram_n_cs, ram_n_oe, ram_n_we},
               ram_d, FLOAT);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_write_timing();
    logic [2:0]    exp_ctl;
    logic [DW-1:0] exp_d;
    bit            in_wr;
    req = 1'b1; we = 1'b1; addr = 15'h1234; wdata = 8'hA5;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = AW'($urandom); wdata = DW'($urandom);
    for (int i = 1; i <= WR_LAT; i++) begin
      @(negedge clk);
      in_wr   = (i <= WS + WP + WH);
      exp_ctl = {!in_wr, 1'b1, !(i > WS && i <= WS + WP)};
      exp_d   = in_wr ? 8'hA5 : FLOAT;
      checks++;
      if ({ram_n_cs, ram_n_oe, ram_n_we} !== exp_ctl) begin
        errors++;
        $display("FAIL wr_ctl cyc%0d got %b exp %b", i, {ram_n_cs, ram_n_oe, ram_n_we}, exp_ctl);
      end
      checks++;
      if (ram_d !== exp_d || (in_wr && ram_a !== 15'h1234)) begin
        errors++;
        $display("FAIL wr_bus cyc%0d d=%h a=%h exp %h/1234", i, ram_d, ram_a, exp_d);
      end
      checks++;
      if (ack !== (i == WR_LAT) || ready !== 1'b0) begin
        errors++;
        $display("FAIL wr_ack cyc%0d ack=%b ready=%b exp %b/0", i, ack, ready, i == WR_LAT);
      end
    end
    ref_mem[32'h1234] = 8'hA5;
    addr_q.push_back(32'h1234);
  endtask

  task automatic test_read_timing();
    logic [2:0]    exp_ctl;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 15'h1234;
    @(posedge clk);
    #1;
    req = 1'b0; addr = AW'($urandom); we = 1'b1;
    for (int i = 1; i <= RD_LAT; i++) begin
      @(negedge clk);
      exp_ctl = (i <= RDW) ? 3'b001 : 3'b111;
      exp_rd  = (i == RD_LAT) ? 8'hA5 : last_rd;
      checks++;
      if ({ram_n_cs, ram_n_oe, ram_n_we} !== exp_ctl || ack !== (i == RD_LAT)) begin
        errors++;
        $display("FAIL rd_ctl cyc%0d ctl=%b ack=%b exp %b/%b", i,
                 {ram_n_cs, ram_n_oe, ram_n_we}, ack, exp_ctl, i == RD_LAT);
      end
      checks++;
      if (rdata !== exp_rd) begin
        errors++; $display("FAIL rd_data cyc%0d got %h exp %h", i, rdata, exp_rd);
      end
    end
    last_rd = 8'hA5;
  endtask

  task automatic test_back_to_back();
    int ack_seen[$];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = '0; wdata = 8'h11;
    @(posedge clk);
    #1;
    we = 1'b0; wdata = DW'($urandom);  // req stays high: the read follows the write
    for (int i = 1; i <= WR_LAT + 1 + RD_LAT; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_seen.push_back(i);
      if (i == WR_LAT + 1) begin
        checks++;
        if (ready !== 1'b1 || {ram_n_cs, ram_n_oe, ram_n_we} !== 3'b111) begin
          errors++;
          $display("FAIL b2b_gap ready=%b ctl=%b exp 1/111", ready,
                   {ram_n_cs, ram_n_oe, ram_n_we});
        end
      end
      if (i == WR_LAT + 2) req = 1'b0;
    end
    checks++;
    if (ack_seen.size() != 2 || ack_seen[0] != WR_LAT || ack_seen[1] != WR_LAT + 1 + RD_LAT)
    begin
      errors++;
      $display("FAIL b2b_ack acks=%0d first=%0d exp 2 at %0d,%0d", ack_seen.size(),
               (ack_seen.size() > 0) ? ack_seen[0] : -1, WR_LAT, WR_LAT + 1 + RD_LAT);
    end
    checks++;
    if (rdata !== 8'h11) begin
      errors++; $display("FAIL b2b_rdata got %h exp 11", rdata);
    end
    ref_mem[0] = 8'h11;
    addr_q.push_back(0);
    last_rd = 8'h11;
  endtask

  task automatic test_boundary();
    int            lat;
    logic [DW-1:0] rd;
    @(negedge clk);
    access(1'b1, 15'h7FFF, 8'hFF, lat, rd);
    checks++;
    if (lat != WR_LAT || rd !== last_rd) begin
      errors++; $display("FAIL bnd_wr_hi lat=%0d rdata=%h exp %0d/%h", lat, rd, WR_LAT, last_rd);
    end
    access(1'b1, 15'h0000, 8'h00, lat, rd);
    checks++;
    if (lat != WR_LAT) begin
      errors++; $display("FAIL bnd_wr_lo lat=%0d exp %0d", lat, WR_LAT);
    end
    access(1'b0, 15'h7FFF, '0, lat, rd);
    checks++;
    if (lat != RD_LAT || rd !== ref_mem[32'h7FFF]) begin
      errors++; $display("FAIL bnd_rd_hi lat=%0d got %h exp %0d/%h", lat, rd, RD_LAT,
                         ref_mem[32'h7FFF]);
    end
    access(1'b0, 15'h0000, '0, lat, rd);
    checks++;
    if (lat != RD_LAT || rd !== ref_mem[0]) begin
      errors++; $display("FAIL bnd_rd_lo lat=%0d got %h exp %0d/%h", lat, rd, RD_LAT,
                         ref_mem[0]);
    end
    last_rd = ref_mem[0];
  endtask

  task automatic test_reset_abort();
    int            lat;
    logic [DW-1:0] rd;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 15'h0100; wdata = DW'($urandom);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (WS + 1) @(negedge clk);
    checks++;
    if (ram_n_we !== 1'b0) begin
      errors++; $display("FAIL abort_in_wp n_we=%b exp 0", ram_n_we);
    end
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if ({ram_n_cs, ram_n_oe, ram_n_we} !== 3'b111 || ram_d !== FLOAT) begin
      errors++;
      $display("FAIL abort_pins ctl=%b bus=%h exp 111/%h", {ram_n_cs, ram_n_oe, ram_n_we},
               ram_d, FLOAT);
    end
    checks++;
    if ({ready, ack} !== 2'b10 || rdata !== '0 || ram_a !== '0) begin
      errors++;
      $display("FAIL abort_state ready=%b ack=%b rdata=%h a=%h exp 1/0/0/0", ready, ack,
               rdata, ram_a);
    end
    @(negedge clk);
    n_rst = 1'b1;  // request on the very first edge out of reset
    access(1'b0, 15'h1234, '0, lat, rd);
    checks++;
    if (lat != RD_LAT || rd !== ref_mem[32'h1234]) begin
      errors++; $display("FAIL abort_next_rd lat=%0d got %h exp %0d/%h", lat, rd, RD_LAT,
                         ref_mem[32'h1234]);
    end
    last_rd = ref_mem[32'h1234];
  endtask

  task automatic test_random();
    int            lat, a;
    logic [DW-1:0] rd, d;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = int'(AW'($urandom));
        d = DW'($urandom);
        access(1'b1, AW'(a), d, lat, rd);
        checks++;
        if (lat != WR_LAT || rd !== last_rd) begin
          errors++;
          $display("FAIL rnd_wr a=%h lat=%0d rdata=%h exp %0d/%h", a, lat, rd, WR_LAT, last_rd);
        end
      end else begin
        a = addr_q[$urandom_range(addr_q.size() - 1, 0)];
        access(1'b0, AW'(a), '0, lat, rd);
        checks++;
        if (lat != RD_LAT || rd !== ref_mem[a]) begin
          errors++;
          $display("FAIL rnd_rd a=%h lat=%0d got %h exp %0d/%h", a, lat, rd, RD_LAT, ref_mem[a]);
        end
        last_rd = ref_mem[a];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_timing();
    test_read_timing();
    test_back_to_back();
    test_boundary();
    test_reset_abort();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 8: data width.
REQ-002 Parameter A_WIDTH, default 15: address width.
REQ-003 Parameter RD_WAIT, default 4: clock cycles with n_cs/n_oe low before rdata capture; minimum 1.
REQ-004 Parameter WR_SETUP, default 1: cycles d driven, n_we high, before the n_we pulse; minimum 1.
REQ-005 Parameter WR_PULSE, default 2: cycles n_we held low; minimum 1.
REQ-006 Parameter WR_HOLD, default 4: cycles a/d held driven after the n_we rising edge; minimum 1.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 n_rst  input  1  asynchronous, active-low reset.
REQ-009 req  input  1  access request; sampled only while ready=1.
REQ-010 we  input  1  1 = write, 0 = read; sampled with req.
REQ-011 addr  input  A_WIDTH  access address; sampled with req.
REQ-012 wdata  input  D_WIDTH  write data; sampled with req.
REQ-013 ready  output  1  controller idle, able to accept req.
REQ-014 ack  output  1  one-cycle pulse at access completion.
REQ-015 rdata  output  D_WIDTH  read data; valid from ack until the next read ack.
REQ-016 ram_a  output  A_WIDTH  SRAM address pins.
REQ-017 ram_d  inout  D_WIDTH  SRAM data pins; high-Z unless a write state is active.
REQ-018 ram_n_oe, ram_n_we, ram_n_cs  output  1 each  SRAM active-low controls.

Function
REQ-019 States: IDLE, RD, WS, WP, WH, DONE; a down-counter times RD, WS, WP and WH.
REQ-020 IDLE: ready=1, n_cs=n_oe=n_we=1, ram_d high-Z; on req=1, latch addr/we/wdata; go to RD if we=0, else to WS; load the counter.
REQ-021 RD: n_cs=0, n_oe=0, n_we=1, ram_a=latched addr, ram_d high-Z; after RD_WAIT cycles, capture ram_d into rdata on the last RD edge and go to DONE.
REQ-022 WS: n_cs=0, n_oe=1, n_we=1, ram_d=latched wdata; after WR_SETUP cycles, go to WP.
REQ-023 WP: as WS but n_we=0; after WR_PULSE cycles, go to WH.
REQ-024 WH: as WS (n_we=1, d and a still driven, n_cs=0); after WR_HOLD cycles, go to DONE.
REQ-025 DONE: all controls high, ram_d high-Z, ack=1 for exactly this one cycle, ready=0; next state IDLE.
REQ-026 ram_a, ram_d and all control outputs come directly from flops; no glitches.
REQ-027 ram_d never driven while n_oe=0; n_oe and n_we never low together.
REQ-028 DONE guarantees at least one cycle with bus released between back-to-back accesses.
REQ-029 Access latency from the req edge to ack: read = RD_WAIT+1 cycles; write = WR_SETUP+WR_PULSE+WR_HOLD+1 cycles.
REQ-030 req while ready=0 is ignored; addr, we and wdata changes during an access have no effect.
REQ-031 rdata unchanged by writes.

Reset
REQ-032 n_rst=0 immediately, independent of clk, forces: IDLE; ready=1; ack=0; rdata=0; ram_a=0; n_cs=n_oe=n_we=1; ram_d high-Z.
REQ-033 Reset mid-access aborts the access with no ack; n_we returns high at reset assertion.
REQ-034 Exit from reset is synchronous to clk; the first req is accepted on the first rising edge with n_rst=1.

Verification (clk period 20 ns, 55 ns-access async SRAM model attached, defaults)
REQ-035 Write addr=0x1234, wdata=0xA5 -> n_we low 2 cycles; d=0xA5 stable from setup through 4 cycles after n_we rises; ack 8 cycles after req.
REQ-036 Read addr=0x1234 after that write -> rdata=0xA5 at ack, 5 cycles after req; ram_d never driven by the controller.
REQ-037 req held high continuously: write 0x0000<-0x11, then read 0x0000 -> accesses separated by the DONE/IDLE cycles; read returns 0x11; no bus contention.
REQ-038 Boundary addresses 0x7FFF<-0xFF and 0x0000<-0x00, read both back -> 0xFF and 0x00; no aliasing.
REQ-039 n_rst pulsed low during WP of a write to 0x0100 -> n_we high and ram_d high-Z immediately; no ack; ready=1; next read behaves per REQ-021.
REQ-040 Assertion check throughout all scenarios: never n_oe=0 and n_we=0 together; never ram_d driven while n_oe=0; ack width exactly 1 cycle.
